// File: rtl/uart_rx_oversampled_pkg.sv
// Shared UART definitions: receiver FSM state encoding, parity-mode constants and the
// parameter legality check. Intended to be shared with the future transmitter.
package uart_rx_oversampled_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  // Value the XOR over data and parity bits must equal for a clean frame.
  localparam bit ParityEven = 1'b0;
  localparam bit ParityOdd  = 1'b1;

  function automatic bit rx_params_legal(int unsigned data_bits, int unsigned oversample,
                                         int unsigned stop_bits);
    return (data_bits >= 5) && (data_bits <= 9) &&
           (oversample >= 4) && (oversample <= 32) && ((oversample % 2) == 0) &&
           (stop_bits >= 1) && (stop_bits <= 2);
  endfunction

endpackage

// File: rtl/uart_rx_oversampled_if.sv
// Receive-side result bundle between the UART receiver and the register/FIFO layer.
//   valid         : one-cycle pulse per completed frame
//   data          : received word, held until the next valid
//   framing_error : a stop-bit sample was low (qualified by valid, held with data)
//   parity_error  : parity mismatch (qualified by valid, held with data)
//   busy          : receiver is inside a frame
// master = receiver (drives), slave = consumer.
interface uart_rx_oversampled_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 valid;
  logic [DATA_BITS-1:0] data;
  logic                 framing_error;
  logic                 parity_error;
  logic                 busy;

  modport master (output valid, data, framing_error, parity_error, busy);
  modport slave  (input  valid, data, framing_error, parity_error, busy);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input pin, with a parametrised reset value so it
// can be reused for idle-high lines (RX, CTS) and idle-low lines alike.
//   i_CLK     : destination clock
//   i_RESET_N : asynchronous active-low reset
//   i_D       : asynchronous input
//   o_Q       : synchronised output, 2 clocks behind i_D
module uart_rx_sync #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic i_CLK,
  input  logic i_RESET_N,
  input  logic i_D,
  output logic o_Q
);

  logic [1:0] sync_q;

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[0], i_D};
    end
  end

  assign o_Q = sync_q[1];

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: synchronises RX, detects the start bit, rejects false starts by
// re-checking mid start bit, then samples data/parity/stop bits at their centres. Frame format
// (data width, parity, stop bits) and oversample ratio are parameters.
//   i_CLK         : system clock
//   i_RESET_N     : asynchronous active-low reset; aborts any frame in progress
//   i_SAMPLE_TICK : one-cycle strobe at OVERSAMPLE x baud; all FSM/counter motion gated by it
//   i_RX          : asynchronous serial line, idles high
//   rx_if         : received word, error flags, valid pulse and busy
module uart_rx_oversampled
  import uart_rx_oversampled_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic i_CLK,
  input  logic i_RESET_N,
  input  logic i_SAMPLE_TICK,
  input  logic i_RX,
  uart_rx_oversampled_if.master rx_if
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

  localparam logic [TickW-1:0] TickMid     = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickLast    = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLastData = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0]  BitLastStop = BitW'(STOP_BITS - 1);
  localparam bit               ParityMode  = PARITY_ODD ? ParityOdd : ParityEven;

  if (!rx_params_legal(DATA_BITS, OVERSAMPLE, STOP_BITS)) begin : gen_param_check
    $fatal(1, "uart_rx_oversampled: illegal DATA_BITS/OVERSAMPLE/STOP_BITS");
  end

  logic rx_s;

  uart_rx_sync #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .i_CLK     (i_CLK),
    .i_RESET_N (i_RESET_N),
    .i_D       (i_RX),
    .o_Q       (rx_s)
  );

  rx_state_e            state_q, state_d;
  logic [TickW-1:0]     tick_q, tick_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 fe_acc_q, fe_acc_d;
  logic                 pe_acc_q, pe_acc_d;
  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 fe_q, fe_d;
  logic                 pe_q, pe_d;
  logic                 sample_pt;

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_q  <= StIdle;
      tick_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      fe_acc_q <= 1'b0;
      pe_acc_q <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      fe_q     <= 1'b0;
      pe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      fe_acc_q <= fe_acc_d;
      pe_acc_q <= pe_acc_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      fe_q     <= fe_d;
      pe_q     <= pe_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    fe_acc_d  = fe_acc_q;
    pe_acc_d  = pe_acc_q;
    valid_d   = 1'b0;
    data_d    = data_q;
    fe_d      = fe_q;
    pe_d      = pe_q;
    sample_pt = (tick_q == TickLast);

    if (i_SAMPLE_TICK) begin
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_d  = StStart;
            tick_d   = '0;
            fe_acc_d = 1'b0;
            pe_acc_d = 1'b0;
          end
        end
        StStart: begin
          if (tick_q == TickMid) begin
            tick_d = '0;
            if (rx_s) begin
              state_d = StIdle;  // line went back high: glitch, not a start bit
            end else begin
              bit_d   = '0;
              state_d = StData;
            end
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
        StData: begin
          if (sample_pt) begin
            tick_d  = '0;
            shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};  // LSB first: first bit lands in bit 0
            if (bit_q == BitLastData) begin
              bit_d   = '0;
              state_d = PARITY_EN ? StParity : StStop;
            end else begin
              bit_d = bit_q + BitW'(1);
            end
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
        StParity: begin
          if (sample_pt) begin
            tick_d   = '0;
            pe_acc_d = ((^shreg_q) ^ rx_s) != ParityMode;
            state_d  = StStop;
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
        StStop: begin
          if (sample_pt) begin
            tick_d   = '0;
            fe_acc_d = fe_acc_q | ~rx_s;
            if (bit_q == BitLastStop) begin
              // Leave at mid stop bit so a back-to-back start edge is never missed.
              bit_d   = '0;
              state_d = StIdle;
              valid_d = 1'b1;
              data_d  = shreg_q;
              fe_d    = fe_acc_q | ~rx_s;
              pe_d    = pe_acc_q;
            end else begin
              bit_d = bit_q + BitW'(1);
            end
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign rx_if.valid         = valid_q;
  assign rx_if.data          = data_q;
  assign rx_if.framing_error = fe_q;
  assign rx_if.parity_error  = pe_q;
  assign rx_if.busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled. Three receivers share clock and reset:
//   dut_a : defaults (8N1, x16), tick every clock
//   dut_b : 8 data bits, even parity, tick every clock
//   dut_c : 7 data bits, 2 stop bits, tick every 3rd clock
module tb_uart_rx_oversampled;

  typedef struct {
    logic [8:0] data;
    logic       fe;
    logic       pe;
    int         cyc;
  } ev_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic rx_a   = 1'b1;
  logic rx_b   = 1'b1;
  logic rx_c   = 1'b1;
  logic tick_c = 1'b0;
  int   ph     = 0;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  int   t0     = 0;

  ev_t ev_a[$];
  ev_t ev_b[$];
  ev_t ev_c[$];

  uart_rx_oversampled_if #(.DATA_BITS(8)) if_a ();
  uart_rx_oversampled_if #(.DATA_BITS(8)) if_b ();
  uart_rx_oversampled_if #(.DATA_BITS(7)) if_c ();

  uart_rx_oversampled #(
    .DATA_BITS (8), .OVERSAMPLE (16), .PARITY_EN (1'b0), .PARITY_ODD (1'b0), .STOP_BITS (1)
  ) dut_a (
    .i_CLK (clk), .i_RESET_N (rst_n), .i_SAMPLE_TICK (1'b1), .i_RX (rx_a), .rx_if (if_a)
  );

  uart_rx_oversampled #(
    .DATA_BITS (8), .OVERSAMPLE (16), .PARITY_EN (1'b1), .PARITY_ODD (1'b0), .STOP_BITS (1)
  ) dut_b (
    .i_CLK (clk), .i_RESET_N (rst_n), .i_SAMPLE_TICK (1'b1), .i_RX (rx_b), .rx_if (if_b)
  );

  uart_rx_oversampled #(
    .DATA_BITS (7), .OVERSAMPLE (16), .PARITY_EN (1'b0), .PARITY_ODD (1'b0), .STOP_BITS (2)
  ) dut_c (
    .i_CLK (clk), .i_RESET_N (rst_n), .i_SAMPLE_TICK (tick_c), .i_RX (rx_c), .rx_if (if_c)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      ph     = (ph + 1) % 3;
      tick_c = (ph == 0);
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if (if_a.valid) begin
      e.data = {1'b0, if_a.data}; e.fe = if_a.framing_error; e.pe = if_a.parity_error;
      e.cyc = cyc; ev_a.push_back(e);
    end
    if (if_b.valid) begin
      e.data = {1'b0, if_b.data}; e.fe = if_b.framing_error; e.pe = if_b.parity_error;
      e.cyc = cyc; ev_b.push_back(e);
    end
    if (if_c.valid) begin
      e.data = {2'b00, if_c.data}; e.fe = if_c.framing_error; e.pe = if_c.parity_error;
      e.cyc = cyc; ev_c.push_back(e);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic bit tick_now(int which);
    return (which == 2) ? tick_c : 1'b1;
  endfunction

  task automatic set_rx(int which, logic v);
    case (which)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // Returns 1 time unit after the posedge that consumed the n-th tick.
  task automatic wait_ticks(int which, int n);
    int cnt = 0;
    while (cnt < n) begin
      @(posedge clk);
      if (tick_now(which)) cnt++;
    end
    #1;
  endtask

  task automatic align(int which);
    wait_ticks(which, 1);
    t0 = cyc;
  endtask

  // Drives up to nsend bit periods of a frame (start, data LSB first, parity, stops).
  task automatic send_frame(int which, logic [8:0] data, int nbits, bit par_en, bit par_bit,
                            int nstop, bit stop_val, int nsend);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) bits.push_back(data[i]);
    if (par_en) bits.push_back(par_bit);
    for (int i = 0; i < nstop; i++) bits.push_back(stop_val);
    for (int i = 0; i < bits.size() && i < nsend; i++) begin
      set_rx(which, bits[i]);
      wait_ticks(which, 16);
    end
    set_rx(which, 1'b1);
  endtask

  task automatic pop_ev(int which, output ev_t e);
    e.data = 'x; e.fe = 1'bx; e.pe = 1'bx; e.cyc = -1;
    case (which)
      0: if (ev_a.size() > 0) e = ev_a.pop_front();
      1: if (ev_b.size() > 0) e = ev_b.pop_front();
      default: if (ev_c.size() > 0) e = ev_c.pop_front();
    endcase
  endtask

  task automatic wait_negedge_at(int target);
    do @(negedge clk); while (cyc < target);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({if_a.valid, if_a.data, if_a.framing_error, if_a.parity_error, if_a.busy} !== '0) begin
      errors++;
      $display("FAIL reset_a_outputs: got valid=%b data=%h fe=%b pe=%b busy=%b required all 0",
               if_a.valid, if_a.data, if_a.framing_error, if_a.parity_error, if_a.busy);
    end
    checks++;
    if ({if_c.valid, if_c.data, if_c.busy, if_b.busy} !== '0) begin
      errors++;
      $display("FAIL reset_bc_outputs: got c.valid=%b c.data=%h c.busy=%b b.busy=%b required 0",
               if_c.valid, if_c.data, if_c.busy, if_b.busy);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_clean_frame();
    ev_t e;
    align(0);
    send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1, 1'b1, 99);
    wait_ticks(0, 4);
    checks++;
    if (ev_a.size() !== 1) begin
      errors++; $display("FAIL clean_count: got %0d valid pulses required 1", ev_a.size());
    end
    pop_ev(0, e);
    checks++;
    if (e.data !== 9'h055) begin
      errors++; $display("FAIL clean_data: got %h required 055", e.data);
    end
    checks++;
    if ({e.fe, e.pe} !== 2'b00) begin
      errors++; $display("FAIL clean_errors: got fe=%b pe=%b required 0 0", e.fe, e.pe);
    end
    // 2 sync + 1 detect + 8 to mid start + 9 x 16 to mid stop.
    checks++;
    if (e.cyc - t0 !== 155) begin
      errors++; $display("FAIL clean_latency: got %0d clocks required 155", e.cyc - t0);
    end
    @(negedge clk);
    checks++;
    if ({if_a.valid, if_a.data, if_a.busy} !== {1'b0, 8'h55, 1'b0}) begin
      errors++; $display("FAIL clean_hold: got valid=%b data=%h busy=%b required 0 55 0",
                         if_a.valid, if_a.data, if_a.busy);
    end
  endtask

  task automatic test_false_start();
    align(0);
    set_rx(0, 1'b0);
    wait_ticks(0, 4);
    set_rx(0, 1'b1);
    wait_negedge_at(t0 + 10);
    checks++;
    if (if_a.busy !== 1'b1) begin
      errors++; $display("FAIL false_start_busy_mid: got %b required 1", if_a.busy);
    end
    @(negedge clk);
    checks++;
    if (if_a.busy !== 1'b0) begin
      errors++; $display("FAIL false_start_busy_end: got %b required 0", if_a.busy);
    end
    wait_ticks(0, 40);
    checks++;
    if (ev_a.size() !== 0) begin
      errors++; $display("FAIL false_start_no_valid: got %0d pulses required 0", ev_a.size());
    end
  endtask

  task automatic test_framing();
    ev_t e;
    align(0);
    send_frame(0, 9'h0A3, 8, 1'b0, 1'b0, 1, 1'b0, 99);
    wait_ticks(0, 32);
    checks++;
    if (ev_a.size() !== 1) begin
      errors++; $display("FAIL framing_count: got %0d pulses required 1", ev_a.size());
    end
    pop_ev(0, e);
    checks++;
    if ({e.data, e.fe, e.pe} !== {9'h0A3, 1'b1, 1'b0}) begin
      errors++; $display("FAIL framing_bad_stop: got data=%h fe=%b pe=%b required 0a3 1 0",
                         e.data, e.fe, e.pe);
    end
    checks++;
    if (if_a.busy !== 1'b0) begin
      errors++; $display("FAIL framing_break_idle: got busy=%b required 0", if_a.busy);
    end
    align(0);
    send_frame(0, 9'h00F, 8, 1'b0, 1'b0, 1, 1'b1, 99);
    wait_ticks(0, 4);
    pop_ev(0, e);
    checks++;
    if ({e.data, e.fe} !== {9'h00F, 1'b0}) begin
      errors++; $display("FAIL framing_recover: got data=%h fe=%b required 00f 0", e.data, e.fe);
    end
  endtask

  task automatic test_parity();
    ev_t e;
    align(1);
    send_frame(1, 9'h007, 8, 1'b1, 1'b1, 1, 1'b1, 99);
    align(1);
    send_frame(1, 9'h007, 8, 1'b1, 1'b0, 1, 1'b1, 99);
    wait_ticks(1, 4);
    checks++;
    if (ev_b.size() !== 2) begin
      errors++; $display("FAIL parity_count: got %0d pulses required 2", ev_b.size());
    end
    pop_ev(1, e);
    checks++;
    if ({e.data, e.fe, e.pe} !== {9'h007, 1'b0, 1'b0}) begin
      errors++; $display("FAIL parity_good: got data=%h fe=%b pe=%b required 007 0 0",
                         e.data, e.fe, e.pe);
    end
    pop_ev(1, e);
    checks++;
    if ({e.data, e.fe, e.pe} !== {9'h007, 1'b0, 1'b1}) begin
      errors++; $display("FAIL parity_bad: got data=%h fe=%b pe=%b required 007 0 1",
                         e.data, e.fe, e.pe);
    end
  endtask

  task automatic test_back_to_back();
    ev_t e1;
    ev_t e2;
    align(2);
    send_frame(2, 9'h041, 7, 1'b0, 1'b0, 2, 1'b1, 99);
    send_frame(2, 9'h03E, 7, 1'b0, 1'b0, 2, 1'b1, 99);
    wait_ticks(2, 4);
    checks++;
    if (ev_c.size() !== 2) begin
      errors++; $display("FAIL b2b_count: got %0d pulses required 2", ev_c.size());
    end
    pop_ev(2, e1);
    pop_ev(2, e2);
    checks++;
    if ({e1.data, e1.fe} !== {9'h041, 1'b0}) begin
      errors++; $display("FAIL b2b_first: got data=%h fe=%b required 041 0", e1.data, e1.fe);
    end
    checks++;
    if ({e2.data, e2.fe} !== {9'h03E, 1'b0}) begin
      errors++; $display("FAIL b2b_second: got data=%h fe=%b required 03e 0", e2.data, e2.fe);
    end
    // 10 bits x 16 ticks x 3 clocks per tick.
    checks++;
    if (e2.cyc - e1.cyc !== 480) begin
      errors++; $display("FAIL b2b_spacing: got %0d clocks required 480", e2.cyc - e1.cyc);
    end
  endtask

  task automatic test_reset_mid_frame();
    ev_t e;
    align(0);
    send_frame(0, 9'h000, 8, 1'b0, 1'b0, 1, 1'b1, 5);
    set_rx(0, 1'b0);
    wait_ticks(0, 8);
    checks++;
    if ({if_a.busy, if_a.data} !== {1'b1, 8'h0F}) begin
      errors++; $display("FAIL reset_mid_before: got busy=%b data=%h required 1 0f",
                         if_a.busy, if_a.data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({if_a.valid, if_a.data, if_a.framing_error, if_a.parity_error, if_a.busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got valid=%b data=%h fe=%b pe=%b busy=%b required 0",
               if_a.valid, if_a.data, if_a.framing_error, if_a.parity_error, if_a.busy);
    end
    set_rx(0, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(0, 64);
    checks++;
    if ({ev_a.size() == 0, if_a.busy} !== 2'b10) begin
      errors++; $display("FAIL reset_mid_residual: got pulses=%0d busy=%b required 0 0",
                         ev_a.size(), if_a.busy);
    end
    align(0);
    send_frame(0, 9'h0C3, 8, 1'b0, 1'b0, 1, 1'b1, 99);
    wait_ticks(0, 4);
    pop_ev(0, e);
    checks++;
    if ({e.data, e.fe, e.pe} !== {9'h0C3, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_mid_next: got data=%h fe=%b pe=%b required 0c3 0 0",
                         e.data, e.fe, e.pe);
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_false_start();
    test_framing();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

Parametrised UART receiver that replaces the fixed 8N1 one-sample-per-bit receiver. It adds an input synchroniser, configurable data width, parity and stop-bit count, and oversampled mid-bit sampling with false-start rejection. It sits between the pad-side RX pin and the UART register and FIFO layer, driven by the shared baud-rate oversample tick.

## Interface
- DATA_BITS, 8, data bits per frame; legal range 5..9; LSB first.
- OVERSAMPLE, 16, ticks per bit period; even, 4..32.
- PARITY_EN, 0, 1 adds a parity bit after the data bits.
- PARITY_ODD, 0, 1 selects odd parity, 0 selects even; ignored when PARITY_EN=0.
- STOP_BITS, 1, stop bits per frame; 1 or 2.
- i_CLK, input, 1, system clock; all logic on rising edge.
- i_RESET_N, input, 1, reset: one clock; reset is asynchronous and active-low.
- i_SAMPLE_TICK, input, 1, one-cycle oversample strobe at OVERSAMPLE × baud.
- i_RX, input, 1, asynchronous serial line; idles high.
- o_VALID, output, 1, one-cycle pulse when a frame completes.
- o_DATA, output, DATA_BITS, received word; held until the next o_VALID.
- o_FRAMING_ERROR, output, 1, any stop-bit sample low; qualified by o_VALID, held with o_DATA.
- o_PARITY_ERROR, output, 1, parity mismatch; qualified by o_VALID, held; always 0 when PARITY_EN=0.
- o_BUSY, output, 1, high whenever state is not IDLE.

## Operation
- i_RX passes through a 2-flop synchroniser, reset value 1. All decisions use the synchronised value, rx_s.
- The FSM, tick counter and bit counter advance only on cycles where i_SAMPLE_TICK=1. On other cycles all state holds, apart from o_VALID clearing.
- States are IDLE, START, DATA, PARITY and STOP.
- **IDLE:** on a tick with rx_s=0, go to START and clear tick_cnt.
- **START:** on each tick, tick_cnt increments. When tick_cnt reaches OVERSAMPLE/2−1, sample rx_s:
  - sample = 1 is a false start: return to IDLE with no output.
  - sample = 0: clear tick_cnt and bit_cnt, then go to DATA.
- **DATA:** sample when tick_cnt = OVERSAMPLE−1, then clear tick_cnt.
  - Each sample shifts into shreg from the MSB side, so the first bit received ends at bit 0.
  - After DATA_BITS samples, go to PARITY if PARITY_EN=1, otherwise to STOP.
- **PARITY:** one sample, same timing as DATA. The error flag is set when XOR(data bits, parity bit) ≠ PARITY_ODD.
- **STOP:** STOP_BITS samples, same timing as DATA. Any low sample sets the framing flag.
- **After the last stop sample:**
  - Go to IDLE on that same tick; the rest of the stop bit is not waited out.
  - On the next clock, o_VALID=1. o_DATA, o_FRAMING_ERROR and o_PARITY_ERROR load from shreg and the flags.
  - A framing error does not suppress the data; o_DATA still loads the shifted bits.
- **Line held low:** a line held low after a framing error (break) is treated as a new start bit on the next tick in IDLE.
- **Reset values:**
  - All outputs are 0.
  - FSM is IDLE, counters are 0, shreg is 0, synchroniser flops are 1.
- **Reset mid-frame:** the frame is aborted immediately, with no o_VALID and no residual state.
- **Width rules:**
  - tick_cnt is $clog2(OVERSAMPLE) bits.
  - bit_cnt is $clog2(DATA_BITS+1) bits.
  - tick_cnt wraps explicitly to 0 at the sample point and never relies on overflow.

## Timing
- **Synchroniser delay:** 2 clocks from an i_RX edge to rx_s.
- **Start detect:** the falling edge is recognised on the first tick after rx_s goes low.
- **Sample points:** the start sample falls OVERSAMPLE/2 ticks after detection (mid start bit). Each subsequent sample follows OVERSAMPLE ticks later.
- **Output latency:** o_VALID rises exactly 1 clock after the tick that takes the last stop sample, and is high for exactly 1 clock.
- **Back-to-back frames:** a start bit immediately following the stop bit is accepted with no lost frame. A new frame may begin while o_VALID is high.
- **Throughput:** one frame per (1+DATA_BITS+PARITY_EN+STOP_BITS)·OVERSAMPLE ticks.

## Structure
- uart_pkg.vh holds:
  - state encodings: IDLE, START, DATA, PARITY, STOP;
  - parity-mode constants;
  - the legal-range checks for the parameters. The same package is shared with the future transmitter.
- Sub-module uart_rx_sync: 2-flop synchroniser with parametrised reset value, reused for CTS and other pins.
- FSM, counters and shift register stay in one module.

## Test plan
- **Clean frame:** defaults, tick every clock, send 0x55 8N1 → one o_VALID pulse 1 clock after the mid stop sample, o_DATA=0x55, both errors 0.
- **False start:** pull i_RX low for 4 ticks, then high → no o_VALID; o_BUSY returns to 0 by tick 8.
- **Framing error:** send 0xA3 with the stop bit low → o_VALID, o_DATA=0xA3, o_FRAMING_ERROR=1. A following frame of 0x0F with a good stop bit gives o_FRAMING_ERROR=0.
- **Parity:** PARITY_EN=1, PARITY_ODD=0; send 0x07 with parity 1 → o_PARITY_ERROR=0. Send 0x07 with parity 0 → o_PARITY_ERROR=1.
- **Back-to-back:** DATA_BITS=7, STOP_BITS=2, tick every 3rd clock; send 0x41 then 0x3E with zero gap → two o_VALID pulses, o_DATA=0x41 then 0x3E.
- **Reset mid-frame:** drop i_RESET_N during data bit 4 → outputs 0 and o_BUSY=0 immediately. The next clean frame of 0xC3 is received correctly.
